// File: rtl/key_debounce_multi_pkg.sv
// ============================================================================
// Module   : key_pkg
// Brief    : Shared types, default 50 MHz timing and width helper for the
//            multi-channel key debouncer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package key_pkg;

    typedef enum logic [1:0] {
        REL = 2'd0,
        PRS = 2'd1,
        LNG = 2'd2
    } key_fsm_e;

    localparam int DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int DEF_LONG_CYC     = 50_000_000;
    localparam int DEF_REPEAT_CYC   = 10_000_000;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_multi_ch.sv
// ============================================================================
// Module   : key_debounce_ch
// Brief    : One key channel: 2-flop synchroniser, stability counter and
//            REL/PRS/LNG event FSM with hold and repeat counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter int REPEAT_EN    = 1,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic press_next
);

    localparam int DW = cnt_width(DEBOUNCE_CYC);
    localparam int HW = cnt_width(LONG_CYC);
    localparam int RW = cnt_width(REPEAT_CYC);

    localparam logic          RELEASED_LVL = (ACTIVE_LOW != 0);
    localparam logic [DW-1:0] DB_LAST      = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] LONG_LAST    = HW'(LONG_CYC - 1);
    localparam logic [RW-1:0] RPT_LAST     = RW'(REPEAT_CYC - 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [DW-1:0] cnt_q, cnt_d;
    key_fsm_e      fsm_q, fsm_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          pressed;
    logic          accept;

    always_comb begin
        sync_d    = {sync_q[0], key_in};
        level_d   = level_q;
        cnt_d     = cnt_q;
        fsm_d     = fsm_q;
        hold_d    = hold_q;
        rpt_d     = rpt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        accept    = 1'b0;
        pressed   = sync_q[1] ^ RELEASED_LVL;

        if (pressed == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            level_d = pressed;
            cnt_d   = '0;
            accept  = 1'b1;
        end else begin
            cnt_d = cnt_q + DW'(1);
        end

        // An accepted release is tested first so it pre-empts long/repeat.
        case (fsm_q)
            REL: begin
                if (accept && pressed) begin
                    fsm_d   = PRS;
                    press_d = 1'b1;
                    hold_d  = '0;
                end
            end
            PRS: begin
                if (accept && !pressed) begin
                    fsm_d     = REL;
                    release_d = 1'b1;
                    hold_d    = '0;
                    rpt_d     = '0;
                end else if (hold_q == LONG_LAST) begin
                    fsm_d  = LNG;
                    long_d = 1'b1;
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            LNG: begin
                if (accept && !pressed) begin
                    fsm_d     = REL;
                    release_d = 1'b1;
                    hold_d    = '0;
                    rpt_d     = '0;
                end else if (REPEAT_EN != 0) begin
                    if (rpt_q == RPT_LAST) begin
                        rpt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        rpt_d = rpt_q + RW'(1);
                    end
                end
            end
            default: fsm_d = REL;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q    <= {2{RELEASED_LVL}};
            level_q   <= 1'b0;
            cnt_q     <= '0;
            fsm_q     <= REL;
            hold_q    <= '0;
            rpt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            fsm_q     <= fsm_d;
            hold_q    <= hold_d;
            rpt_q     <= rpt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign key_state     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign press_next    = press_d;

endmodule

`default_nettype wire

// File: rtl/key_debounce_multi.sv
// ============================================================================
// Module   : key_debounce_multi
// Brief    : N-channel key debouncer and press/release/long/repeat event
//            generator with a combined any_press flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_debounce_multi
    import key_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter int REPEAT_EN    = 1,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse,
    output logic                any_press
);

    logic [NUM_KEYS-1:0] press_next;
    logic                any_press_q, any_press_d;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC),
            .REPEAT_EN    (REPEAT_EN),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .sys_clk       (sys_clk),
            .sys_rst       (sys_rst),
            .key_in        (key_in[k]),
            .key_state     (key_state[k]),
            .press_pulse   (press_pulse[k]),
            .release_pulse (release_pulse[k]),
            .long_pulse    (long_pulse[k]),
            .repeat_pulse  (repeat_pulse[k]),
            .press_next    (press_next[k])
        );
    end

    // Built from next-state press bits so it lands in the same cycle.
    always_comb begin
        any_press_d = |press_next;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign any_press = any_press_q;

endmodule

`default_nettype wire
